// File: rtl/rft_coeff_energy_stage.sv
// Per-coefficient energy |y[k]|^2 with a running frame summary: total, peak and frame count.
// Latency 2 cycles from input handshake to out_valid, 1 element per cycle sustained.
// Backpressure: both stages hold while out_valid && !out_ready; in_ready follows that stall.
module rft_coeff_energy_stage #(
  parameter int N        = 64,
  parameter int COEF_W   = 32,
  parameter int ENERGY_W = 2*COEF_W,
  parameter int ACC_W    = ENERGY_W + $clog2(N),
  parameter int IDX_W    = $clog2(N)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [COEF_W-1:0]   in_real,
  input  logic signed [COEF_W-1:0]   in_imag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ENERGY_W-1:0]        out_energy,
  output logic [IDX_W-1:0]           out_k,
  output logic                       out_last,
  output logic                       sum_valid,
  output logic [ACC_W-1:0]           sum_energy,
  output logic [ENERGY_W-1:0]        peak_energy,
  output logic [IDX_W-1:0]           peak_k,
  output logic [31:0]                frame_count
);

  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N-1);

  logic                       adv;
  logic [IDX_W-1:0]           in_k;
  logic                       s1_valid;
  logic [ENERGY_W-1:0]        s1_rr;
  logic [ENERGY_W-1:0]        s1_ii;
  logic [IDX_W-1:0]           s1_k;
  logic signed [ENERGY_W-1:0] re_ext;
  logic signed [ENERGY_W-1:0] im_ext;
  logic signed [ENERGY_W-1:0] rr_prod;
  logic signed [ENERGY_W-1:0] ii_prod;
  logic [ENERGY_W-1:0]        e_next;
  logic [ACC_W-1:0]           acc;
  logic [ACC_W-1:0]           acc_next;
  logic [ENERGY_W-1:0]        pk_e;
  logic [ENERGY_W-1:0]        pk_e_next;
  logic [IDX_W-1:0]           pk_k;
  logic [IDX_W-1:0]           pk_k_next;

  // The whole pipeline moves together unless the output register is full and blocked.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Sign-extend before multiplying so the square of -2^(COEF_W-1) is exact.
  assign re_ext  = ENERGY_W'(in_real);
  assign im_ext  = ENERGY_W'(in_imag);
  assign rr_prod = re_ext * re_ext;
  assign ii_prod = im_ext * im_ext;

  // Energy of the element entering S2 and the frame state it would produce; k==0 restarts.
  always_comb begin
    e_next    = s1_rr + s1_ii;
    acc_next  = acc + ACC_W'(e_next);
    pk_e_next = pk_e;
    pk_k_next = pk_k;
    if (s1_k == '0) begin
      acc_next  = ACC_W'(e_next);
      pk_e_next = e_next;
      pk_k_next = s1_k;
    end else if (e_next > pk_e) begin
      pk_e_next = e_next;
      pk_k_next = s1_k;
    end
  end

  // Input index counter: frames are defined purely by the accepted-element count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_k <= '0;
    end else if (in_valid && adv) begin
      in_k <= in_k + IDX_W'(1);
    end
  end

  // S1: squares of both components plus the index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_rr    <= '0;
      s1_ii    <= '0;
      s1_k     <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_rr <= unsigned'(rr_prod);
        s1_ii <= unsigned'(ii_prod);
        s1_k  <= in_k;
      end
    end
  end

  // S2: energy sum, drives the output port registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_energy <= '0;
      out_k      <= '0;
      out_last   <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_energy <= e_next;
        out_k      <= s1_k;
        out_last   <= (s1_k == K_LAST);
      end
    end
  end

  // Frame accumulation and summary latch; sum_valid is a single unstalled pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      pk_e        <= '0;
      pk_k        <= '0;
      sum_valid   <= 1'b0;
      sum_energy  <= '0;
      peak_energy <= '0;
      peak_k      <= '0;
      frame_count <= '0;
    end else begin
      sum_valid <= 1'b0;
      if (adv && s1_valid) begin
        acc  <= acc_next;
        pk_e <= pk_e_next;
        pk_k <= pk_k_next;
        if (s1_k == K_LAST) begin
          sum_valid   <= 1'b1;
          sum_energy  <= acc_next;
          peak_energy <= pk_e_next;
          peak_k      <= pk_k_next;
          frame_count <= frame_count + 32'd1;
        end
      end
    end
  end

endmodule
